// File: rtl/ctb_count_monitor.sv
// Receive-side monitor for the odd/even counter: captures each count on tick fall, checks the +2 stepping rule,
// and drives a 2-digit multiplexed active-low 7-segment display. Optional watchdog: CTB_MON_STALL_DETECT_EN.
module ctb_count_monitor #(
  parameter int REFRESH_W = 16
`ifdef CTB_MON_STALL_DETECT_EN
  , parameter int STALL_CYCLES = 150000000
`endif
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic [3:0] q_in,
  input  logic       m,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] disp_val,
  output logic       err_pulse,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       stall
);

  localparam logic [REFRESH_W-1:0] RC_ONE = {{(REFRESH_W-1){1'b0}}, 1'b1};

  logic                 r_t1, r_t2, r_t3, r_ev, r_cap_v;
  logic [3:0]           r_q_cap, r_prev;
  logic                 r_m_cap, r_m_prev, r_primed, r_cap_resync;
  logic [REFRESH_W-1:0] r_rc;
  logic                 w_stall;
  logic                 w_fail;
  logic                 w_tens;
  logic [3:0]           w_ones;

  // A capture is only judged against history when the mode is unchanged and no stall intervened.
  assign w_fail = r_primed && (r_m_cap == r_m_prev) && !r_cap_resync &&
                  ((r_q_cap != r_prev + 4'd2) || (r_q_cap[0] != r_m_cap));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_t1         <= 1'b0;
      r_t2         <= 1'b0;
      r_t3         <= 1'b0;
      r_ev         <= 1'b0;
      r_cap_v      <= 1'b0;
      r_q_cap      <= 4'd0;
      r_m_cap      <= 1'b0;
      r_cap_resync <= 1'b0;
      r_prev       <= 4'd0;
      r_m_prev     <= 1'b0;
      r_primed     <= 1'b0;
      disp_val     <= 4'd0;
      err_pulse    <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      r_t1      <= tick;
      r_t2      <= r_t1;
      r_t3      <= r_t2;
      r_ev      <= r_t3 & ~r_t2;
      r_cap_v   <= r_ev;
      err_pulse <= 1'b0;
      if (r_ev) begin
        r_q_cap      <= q_in;
        r_m_cap      <= m;
        disp_val     <= q_in;
        r_cap_resync <= w_stall;
      end
      if (r_cap_v) begin
        if (w_fail) begin
          err_pulse <= 1'b1;
          err       <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        r_prev   <= r_q_cap;
        r_m_prev <= r_m_cap;
        r_primed <= 1'b1;
      end
    end
  end

`ifdef CTB_MON_STALL_DETECT_EN
  localparam logic [27:0] WD_LIM = 28'(STALL_CYCLES);
  logic [27:0] r_wd;
  logic        r_stall;

  // Watchdog saturates at the limit so a long outage never wraps back to "healthy".
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wd    <= 28'd0;
      r_stall <= 1'b0;
    end else if (r_ev) begin
      r_wd    <= 28'd0;
      r_stall <= 1'b0;
    end else begin
      if (r_wd < WD_LIM) r_wd <= r_wd + 28'd1;
      if (r_wd >= WD_LIM - 28'd1) r_stall <= 1'b1;
    end
  end

  assign w_stall = r_stall;
`else
  assign w_stall = 1'b0;
`endif

  assign stall = w_stall;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    p = 7'h7F;
    case (d)
      4'd0: p = 7'h40;
      4'd1: p = 7'h79;
      4'd2: p = 7'h24;
      4'd3: p = 7'h30;
      4'd4: p = 7'h19;
      4'd5: p = 7'h12;
      4'd6: p = 7'h02;
      4'd7: p = 7'h78;
      4'd8: p = 7'h00;
      4'd9: p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  assign w_tens = (disp_val >= 4'd10);
  assign w_ones = w_tens ? (disp_val - 4'd10) : disp_val;

  // Tens digit is blanked rather than showing a leading zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rc <= '0;
      seg  <= 7'h7F;
      an   <= 2'b11;
    end else begin
      r_rc <= r_rc + RC_ONE;
      if (r_rc[REFRESH_W-1]) begin
        an  <= 2'b01;
        seg <= w_tens ? seg7(4'd1) : 7'h7F;
      end else begin
        an  <= 2'b10;
        seg <= seg7(w_ones);
      end
    end
  end

endmodule

// File: tb/tb_ctb_count_monitor.sv
// Bench for ctb_count_monitor: directed sequences plus randomized steps scored against a rule-level model.
module tb_ctb_count_monitor;
  localparam int RW = 4;

  logic       clk = 1'b0;
  logic       clr, tick, m;
  logic [3:0] q_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] disp_val;
  logic       err_pulse, err, stall;
  logic [7:0] err_cnt;

  ctb_count_monitor #(.REFRESH_W(RW)) dut (
    .clk(clk), .clr(clr), .tick(tick), .q_in(q_in), .m(m),
    .seg(seg), .an(an), .disp_val(disp_val), .err_pulse(err_pulse),
    .err(err), .err_cnt(err_cnt), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int mdl_prev, mdl_mprev, mdl_disp, mdl_cnt;
  bit mdl_primed, mdl_err;
  logic [6:0] pat [0:9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic mdl_reset();
    mdl_prev = 0; mdl_mprev = 0; mdl_disp = 0; mdl_cnt = 0;
    mdl_primed = 0; mdl_err = 0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 2'b11);
    chk("rst_disp", disp_val, 4'd0);
    chk("rst_pulse", err_pulse, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", err_cnt, 8'd0);
    chk("rst_stall", stall, 1'b0);
    clr = 1'b0;
    mdl_reset();
  endtask

  // One counter update: junk on q_in/m while tick is high, real value presented at the fall.
  task automatic step(input logic [3:0] q, input logic mm);
    bit fail;
    int pulses;
    logic p5;
    @(negedge clk);
    q_in = 4'($urandom); m = 1'($urandom); tick = 1'b1;
    repeat (3) @(negedge clk);
    q_in = q; m = mm; tick = 1'b0;
    pulses = 0; p5 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (err_pulse === 1'b1) pulses++;
      if (k == 5) p5 = err_pulse;
    end
    fail = mdl_primed && (int'(mm) == mdl_mprev) &&
           ((int'(q) != (mdl_prev + 2) % 16) || (int'(q) % 2 != int'(mm)));
    if (fail) begin
      mdl_err = 1;
      if (mdl_cnt < 255) mdl_cnt++;
    end
    mdl_prev = int'(q); mdl_mprev = int'(mm); mdl_primed = 1; mdl_disp = int'(q);
    chk("pulse_at_check", p5, fail);
    chk("pulse_count", pulses, fail);
    chk("disp_val", disp_val, mdl_disp);
    chk("err", err, mdl_err);
    chk("err_cnt", err_cnt, mdl_cnt);
    chk("stall", stall, 1'b0);
    q_in = 4'($urandom);
  endtask

  task automatic disp_check();
    int t;
    int tens, ones;
    tens = (mdl_disp >= 10) ? 1 : 0;
    ones = mdl_disp - 10 * tens;
    t = 0;
    while (an !== 2'b10 && t < 40) begin @(negedge clk); t++; end
    chk("an_ones", an, 2'b10);
    chk("seg_ones", seg, pat[ones]);
    t = 0;
    while (an !== 2'b01 && t < 40) begin @(negedge clk); t++; end
    chk("an_tens", an, 2'b01);
    chk("seg_tens", seg, (tens == 1) ? pat[1] : 7'h7F);
  endtask

  initial begin
    logic cur_m;
    logic [3:0] nq;
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
    pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
    clr = 1'b1; tick = 1'b0; q_in = 4'd0; m = 1'b0;
    mdl_reset();
    repeat (2) @(negedge clk);
    do_clr();

    // even sequence with 14 -> 0 wrap
    for (int v = 2; v <= 14; v += 2) begin
      step(4'(v), 1'b0);
      if (v == 14) disp_check();
    end
    step(4'd0, 1'b0);
    disp_check();

    // odd sequence with 15 -> 1 wrap; mode change makes the first capture a resync
    for (int v = 1; v <= 15; v += 2) begin
      step(4'(v), 1'b1);
      if (v == 3 || v == 15) disp_check();
    end
    step(4'd1, 1'b1);

    // mode toggle between ticks
    step(4'd6, 1'b0);
    step(4'd1, 1'b1);
    step(4'd3, 1'b1);

    // skipped value: one error, then sticky through good steps
    step(4'd2, 1'b0);
    step(4'd4, 1'b0);
    step(4'd8, 1'b0);
    step(4'd10, 1'b0);
    step(4'd12, 1'b0);
    chk("err_sticky", err, 1'b1);
    chk("err_cnt_one", err_cnt, 8'd1);

    // randomized mix of good steps, bad steps and mode changes
    cur_m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) cur_m = ~cur_m;
      if ($urandom_range(0, 3) == 0) nq = 4'($urandom_range(0, 15));
      else nq = 4'((mdl_prev + 2) % 16);
      step(nq, cur_m);
      if (i % 10 == 9) disp_check();
    end

    // saturation of the error counter
    for (int i = 0; i < 300; i++) step(4'((mdl_prev + 4) % 16), 1'b0);
    chk("err_cnt_sat", err_cnt, 8'd255);

    // clear mid-sequence; the next capture is unchecked even though it is off-sequence
    do_clr();
    step(4'd9, 1'b0);
    chk("post_clr_unchecked", err_cnt, 8'd0);
    step(4'd11, 1'b0);
    disp_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
